usb_tx_serializer: RTL and testbench

- Transmit-side counterpart of the team's USB device receive path.
- Accepts packet bytes over a valid/ready handshake and serialises them onto the USB differential pair (usb_dp/usb_dm), full-speed signalling.
- Generates SYNC, LSB-first data with bit stuffing and NRZI encoding, and EOP.
- Drives the output-enable for the external transceiver.

---
 rtl/usb_pkg.sv | 26 ++
 rtl/usb_nrzi_stuffer.sv | 40 ++++
 rtl/usb_tx_serializer.sv | 216 +++++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: line states, SYNC/EOP framing constants
// and the serializer state encoding.
package usb_pkg;

    // Line states as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam int unsigned EOP_SE0_BITS = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } tx_state_t;

    // NRZI level 1 is idle J, level 0 is K.
    function automatic logic [1:0] nrzi_line(input logic level);
        return level ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI encoder with bit stuffing: owns the consecutive-ones counter and the
// line level register. Disabled means idle (J level, count cleared).
module usb_nrzi_stuffer #(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_bit,
    input  logic bit_strobe,
    input  logic enable,
    output logic level,
    output logic stall
);

    localparam int unsigned    CW        = $clog2(STUFF_LEN + 1);
    localparam logic [CW-1:0]  STUFF_MAX = CW'(STUFF_LEN);

    logic [CW-1:0] ones;

    // Next strobe inserts a stuffed 0 and ignores tx_bit.
    assign stall = (ones == STUFF_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b1;
            ones  <= '0;
        end else if (!enable) begin
            level <= 1'b1;
            ones  <= '0;
        end else if (bit_strobe) begin
            if (stall || !tx_bit) begin
                level <= ~level;
                ones  <= '0;
            end else begin
                ones <= ones + 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_serializer.sv
// Full-speed USB transmit serializer: valid/ready byte input with a one-byte
// holding register, SYNC, NRZI + bit-stuffed data, EOP, transceiver enable.
module usb_tx_serializer
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       usb_dp,
    output logic       usb_dm,
    output logic       usb_oe,
    output logic       tx_busy,
    output logic       tx_underrun
);

    localparam int unsigned       CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]        EOP_LAST = 2'(EOP_SE0_BITS - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       sidx;
    logic [3:0]       bidx;
    logic [1:0]       eidx;
    logic [7:0]       shift;
    logic             shift_last;
    logic [7:0]       hold;
    logic             hold_valid;
    logic             hold_last;
    logic             last_seen;

    logic adv;
    logic accept;
    logic byte_done;
    logic underrun_now;
    logic emit;
    logic emit_bit;
    logic nrzi_en;
    logic level;
    logic stall;

    // adv marks the edge that ends the current bit time.
    assign adv          = (state != IDLE) && (cnt == CNT_LAST);
    assign byte_done    = (state == DATA) && (bidx == 4'd8);
    assign underrun_now = adv && byte_done && !shift_last && !hold_valid;
    assign accept       = tx_valid && tx_ready;

    // The underrun edge refuses input so a late byte cannot strand in the holding register.
    assign tx_ready = !rst && !hold_valid && !last_seen && !underrun_now &&
                      (state inside {IDLE, SYNC, DATA});

    assign nrzi_en = (state == SYNC) || (state == DATA) || ((state == IDLE) && accept);

    always_comb begin
        emit     = 1'b0;
        emit_bit = 1'b0;
        case (state)
            IDLE: begin
                emit     = accept;
                emit_bit = SYNC_PATTERN[0];
            end
            SYNC: begin
                emit     = adv;
                emit_bit = (sidx == 3'd7) ? hold[0] : SYNC_PATTERN[sidx + 3'd1];
            end
            DATA: begin
                if (adv) begin
                    if (byte_done && shift_last) begin
                        emit = stall;
                    end else if (underrun_now) begin
                        emit = 1'b0;
                    end else if (stall) begin
                        emit = 1'b1;
                    end else if (byte_done) begin
                        emit     = 1'b1;
                        emit_bit = hold[0];
                    end else begin
                        emit     = 1'b1;
                        emit_bit = shift[bidx[2:0]];
                    end
                end
            end
            default: begin
                emit     = 1'b0;
                emit_bit = 1'b0;
            end
        endcase
    end

    usb_nrzi_stuffer #(
        .STUFF_LEN (STUFF_LEN)
    ) u_nrzi (
        .clk        (clk),
        .rst        (rst),
        .tx_bit     (emit_bit),
        .bit_strobe (emit),
        .enable     (nrzi_en),
        .level      (level),
        .stall      (stall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sidx        <= '0;
            bidx        <= '0;
            eidx        <= '0;
            shift       <= '0;
            shift_last  <= 1'b0;
            hold        <= '0;
            hold_valid  <= 1'b0;
            hold_last   <= 1'b0;
            last_seen   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;

            if (state != IDLE) begin
                cnt <= adv ? '0 : cnt + 1'b1;
            end

            if (accept) begin
                hold       <= tx_data;
                hold_valid <= 1'b1;
                hold_last  <= tx_last;
                if (tx_last) begin
                    last_seen <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SYNC;
                        cnt   <= '0;
                        sidx  <= '0;
                    end
                end
                SYNC: begin
                    if (adv) begin
                        if (sidx == 3'd7) begin
                            state      <= DATA;
                            shift      <= hold;
                            shift_last <= hold_last;
                            hold_valid <= 1'b0;
                            bidx       <= stall ? 4'd0 : 4'd1;
                        end else begin
                            sidx <= sidx + 3'd1;
                        end
                    end
                end
                DATA: begin
                    if (adv) begin
                        if (byte_done && shift_last) begin
                            // A pending stuff bit goes out before EOP.
                            if (!stall) begin
                                state <= EOP_SE0;
                                eidx  <= '0;
                            end
                        end else if (underrun_now) begin
                            tx_underrun <= 1'b1;
                            state       <= EOP_SE0;
                            eidx        <= '0;
                        end else if (stall) begin
                            bidx <= bidx;
                        end else if (byte_done) begin
                            shift      <= hold;
                            shift_last <= hold_last;
                            hold_valid <= 1'b0;
                            bidx       <= 4'd1;
                        end else begin
                            bidx <= bidx + 4'd1;
                        end
                    end
                end
                EOP_SE0: begin
                    if (adv) begin
                        if (eidx == EOP_LAST) begin
                            state <= EOP_J;
                        end else begin
                            eidx <= eidx + 2'd1;
                        end
                    end
                end
                EOP_J: begin
                    if (adv) begin
                        state      <= IDLE;
                        last_seen  <= 1'b0;
                        shift_last <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            IDLE:       {usb_dp, usb_dm} = LINE_J;
            SYNC, DATA: {usb_dp, usb_dm} = nrzi_line(level);
            EOP_SE0:    {usb_dp, usb_dm} = LINE_SE0;
            default:    {usb_dp, usb_dm} = LINE_J;
        endcase
    end

    assign usb_oe  = (state != IDLE);
    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboard bench for usb_tx_serializer: packets are expanded into expected
// per-cycle line states by a bit-stream model; a negedge monitor consumes them.
module tb_usb_tx_serializer;

    localparam int CPB = 4;
    localparam int SL  = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       usb_dp;
    logic       usb_dm;
    logic       usb_oe;
    logic       tx_busy;
    logic       tx_underrun;

    usb_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .STUFF_LEN    (SL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .usb_dp      (usb_dp),
        .usb_dm      (usb_dm),
        .usb_oe      (usb_oe),
        .tx_busy     (tx_busy),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] line;
        logic       ur;
    } exp_t;

    exp_t exp_q[$];
    int   len_q[$];
    int   run = 0;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Expand a packet into line symbols: SYNC + LSB-first data as one bit
    // stream, stuff after every SL ones, NRZI, then SE0 SE0 J.
    function automatic void push_expect(input logic [7:0] bytes[$], input bit trunc,
                                        input int exp_bits);
        bit         stream[$];
        logic [1:0] syms[$];
        logic [7:0] b;
        bit         lvl;
        int         ones;
        int         se0_idx;
        exp_t       e;
        for (int i = 0; i < 7; i++) stream.push_back(1'b0);
        stream.push_back(1'b1);
        foreach (bytes[k]) begin
            b = bytes[k];
            for (int j = 0; j < 8; j++) stream.push_back(b[j]);
        end
        lvl  = 1'b1;
        ones = 0;
        for (int i = 0; i < stream.size(); i++) begin
            if (!stream[i]) begin
                lvl  = !lvl;
                ones = 0;
            end else begin
                ones++;
            end
            syms.push_back(lvl ? 2'b10 : 2'b01);
            if (ones == SL && !(trunc && i == stream.size() - 1)) begin
                lvl  = !lvl;
                ones = 0;
                syms.push_back(lvl ? 2'b10 : 2'b01);
            end
        end
        se0_idx = syms.size();
        syms.push_back(2'b00);
        syms.push_back(2'b00);
        syms.push_back(2'b10);
        for (int k = 0; k < syms.size(); k++) begin
            for (int c = 0; c < CPB; c++) begin
                e.line = syms[k];
                e.ur   = trunc && (k == se0_idx) && (c == 0);
                exp_q.push_back(e);
            end
        end
        len_q.push_back((exp_bits > 0 ? exp_bits : syms.size()) * CPB);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            run = 0;
        end else if (mon_en) begin
            if (usb_oe) begin
                run++;
                if (exp_q.size() == 0) begin
                    check("unexpected_oe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("line", {usb_dp, usb_dm}, mon_e.line);
                    check("underrun_pulse", tx_underrun, mon_e.ur);
                end
            end else begin
                check("idle_line", {usb_dp, usb_dm}, 2);
                check("idle_underrun", tx_underrun, 0);
                if (run > 0) begin
                    if (len_q.size() == 0) check("unexpected_oe_run", run, 0);
                    else check("oe_cycles", run, len_q.pop_front());
                    run = 0;
                end
            end
        end
    end

    // Entered and left one time unit after a rising edge.
    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        bit got = 1'b0;
        bit r;
        tx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            r = tx_ready;
            @(posedge clk);
            #1;
            if (r) got = 1'b1;
        end
        if (!got) check("accept_timeout", 0, 1);
        tx_valid = 1'b0;
    endtask

    task automatic finish_packet(input bit check_ready);
        bit done = 1'b0;
        int bad  = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (!tx_busy) done = 1'b1;
            else if (check_ready && tx_ready) bad++;
        end
        if (!done) check("busy_timeout", 0, 1);
        if (check_ready) begin
            check("ready_low_after_last", bad, 0);
            check("ready_first_idle", tx_ready, 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [7:0] bytes[$], input bit trunc,
                               input int exp_bits, input int max_gap);
        push_expect(bytes, trunc, exp_bits);
        foreach (bytes[i]) begin
            send_byte(bytes[i], !trunc && (i == bytes.size() - 1),
                      (i == 0) ? 0 : $urandom_range(max_gap, 0));
        end
        finish_packet(!trunc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pk[$];
        int         any_oe;
        int         n;
        bit         tr;

        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", usb_oe, 0);
        check("rst_line", {usb_dp, usb_dm}, 2);
        check("rst_busy", tx_busy, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_ready", tx_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", tx_ready, 1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        pk = '{8'hA5};             send_packet(pk, 1'b0, 19, 0);
        pk = '{8'hFF};             send_packet(pk, 1'b0, 20, 0);
        pk = '{8'h01, 8'h02, 8'h03}; send_packet(pk, 1'b0, 35, 0);
        pk = '{8'h3C};             send_packet(pk, 1'b1, 19, 0);
        pk = '{8'h7E, 8'hFF};      send_packet(pk, 1'b0, 29, 0);
        pk = '{8'hFC};             send_packet(pk, 1'b0, 20, 0);

        // Asynchronous reset in the middle of a data byte.
        mon_en = 1'b0;
        send_byte(8'hC3, 1'b0, 0);
        repeat (40) @(posedge clk);
        #2;
        check("busy_before_reset", tx_busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_oe", usb_oe, 0);
        check("midrst_line", {usb_dp, usb_dm}, 2);
        check("midrst_busy", tx_busy, 0);
        check("midrst_underrun", tx_underrun, 0);
        check("midrst_ready", tx_ready, 0);
        exp_q.delete();
        len_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        any_oe = 0;
        @(negedge clk);
        check("ready_after_midrst", tx_ready, 1);
        repeat (12) begin
            @(negedge clk);
            if (usb_oe || !usb_dp || usb_dm) any_oe++;
        end
        check("quiet_after_midrst", any_oe, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        for (int p = 0; p < 14; p++) begin
            n  = $urandom_range(4, 1);
            tr = ($urandom_range(4, 0) == 0);
            pk.delete();
            for (int i = 0; i < n; i++) pk.push_back(8'($urandom));
            if (p % 5 == 1) pk[0] = 8'hFF;
            send_packet(pk, tr, 0, 12);
            repeat ($urandom_range(5, 0)) @(posedge clk);
            #1;
        end

        repeat (4) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("len_q_drained", len_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
